// File: rtl/rcas_pipe_nb.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit ripple slice per register stage,
// valid/ready on both sides, global stall when the output register is full and not taken.
module rcas_pipe_nb #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("rcas_pipe_nb: WIDTH must be a non-zero multiple of CHUNK");
  end

  function automatic logic [CHUNK:0] slice_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             ci);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  logic             stall;
  logic [WIDTH-1:0] bx;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign bx       = b ^ {WIDTH{mode}};

  // Inner stages 0..STAGES-2: each resolves its lowest pending slice and forwards only
  // the operand bits still to be added, so the skew registers shrink stage by stage.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_st
    localparam int RW = (k + 1) * CHUNK;
    localparam int OW = WIDTH - RW;

    logic [OW+CHUNK-1:0] ai;
    logic [OW+CHUNK-1:0] bi;
    logic                ci;
    logic                vi;
    logic [CHUNK:0]      s;
    logic [RW-1:0]       rn;

    logic                vld_p;
    logic [OW-1:0]       a_p;
    logic [OW-1:0]       b_p;
    logic [RW-1:0]       r_p;
    logic                cy_p;

    assign s = slice_add(ai[CHUNK-1:0], bi[CHUNK-1:0], ci);

    if (k == 0) begin : g_src
      assign ai = a;
      assign bi = bx;
      assign ci = mode;
      assign vi = in_valid;
      assign rn = s[CHUNK-1:0];
    end else begin : g_chain
      assign ai = g_st[k-1].a_p;
      assign bi = g_st[k-1].b_p;
      assign ci = g_st[k-1].cy_p;
      assign vi = g_st[k-1].vld_p;
      assign rn = {s[CHUNK-1:0], g_st[k-1].r_p};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
      end else if (!stall) begin
        vld_p <= vi;
      end
    end

    always_ff @(posedge clk) begin
      if (!stall) begin
        a_p  <= ai[OW+CHUNK-1:CHUNK];
        b_p  <= bi[OW+CHUNK-1:CHUNK];
        r_p  <= rn;
        cy_p <= s[CHUNK];
      end
    end
  end

  // Final stage: top slice plus flags, registered straight into the output port registers.
  logic [CHUNK-1:0] la;
  logic [CHUNK-1:0] lb;
  logic             lc;
  logic             lv;
  logic [CHUNK:0]   sl;
  logic [WIDTH-1:0] rfin;
  logic             c_msb_in;

  if (STAGES == 1) begin : g_last_src
    assign la   = a;
    assign lb   = bx;
    assign lc   = mode;
    assign lv   = in_valid;
    assign rfin = sl[CHUNK-1:0];
  end else begin : g_last_chain
    assign la   = g_st[STAGES-2].a_p;
    assign lb   = g_st[STAGES-2].b_p;
    assign lc   = g_st[STAGES-2].cy_p;
    assign lv   = g_st[STAGES-2].vld_p;
    assign rfin = {sl[CHUNK-1:0], g_st[STAGES-2].r_p};
  end

  assign sl       = slice_add(la, lb, lc);
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
  assign c_msb_in = la[CHUNK-1] ^ lb[CHUNK-1] ^ sl[CHUNK-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (!stall) begin
      out_valid <= lv;
      res       <= rfin;
      cout      <= sl[CHUNK];
      ovf       <= c_msb_in ^ sl[CHUNK];
      zero      <= ~|rfin;
    end
  end

endmodule
